// File: rtl/cla_addsub_seq_pkg.sv
// Shared definitions for the sequential CLA add/subtract block:
// FSM state encoding and a counter-width helper.
package cla_addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/cla_addsub_seq_group.sv
// One G-bit carry-lookahead group: generate/propagate terms, lookahead carries,
// group sum, carry-out and the carry into the group MSB (for overflow).
module cla_addsub_seq_group #(
    parameter int G = 4
) (
    input  logic [G-1:0] a,
    input  logic [G-1:0] b,
    input  logic         cin,
    output logic [G-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [G-1:0] g_s;
    logic [G-1:0] p_s;
    logic [G:0]   c_s;

    // Generate and propagate terms per bit.
    always_comb begin
        g_s = a & b;
        p_s = a ^ b;
    end

    // Lookahead carry recurrence across the group.
    always_comb begin
        c_s    = '0;
        c_s[0] = cin;
        for (int i = 0; i < G; i++) begin
            c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
        end
    end

    // Group results.
    always_comb begin
        sum   = p_s ^ c_s[G-1:0];
        cout  = c_s[G];
        c_msb = c_s[G-1];
    end

endmodule

// File: rtl/cla_addsub_seq.sv
// Multi-cycle adder/subtractor: one G-bit lookahead group per clock, LSB first,
// with the inter-group carry held in a register. Subtract is a + ~b + ~cin.
module cla_addsub_seq #(
    parameter int N = 32,
    parameter int G = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    import cla_addsub_seq_pkg::*;

    localparam int NG = N / G;
    localparam int CW = (clog2(NG) < 1) ? 1 : clog2(NG);
    localparam logic [CW-1:0] LAST_IDX = CW'(NG - 1);

    state_e        state_r;
    state_e        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic          carry_r;
    logic [N-1:0]  sum_r;
    logic          cout_r;
    logic          ovf_r;
    logic          out_valid_r;
    logic          in_ready_r;

    logic          load_s;
    logic          step_s;
    logic          last_s;
    logic          release_s;
    int            base_s;
    logic [G-1:0]  grp_a_s;
    logic [G-1:0]  grp_b_s;
    logic [G-1:0]  grp_sum_s;
    logic          grp_cout_s;
    logic          grp_c_msb_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_next_s = RUN;
                else          state_next_s = IDLE;
            end
            RUN: begin
                if (cnt_r == LAST_IDX) state_next_s = DONE;
                else                   state_next_s = RUN;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: datapath strobes for the current state.
    always_comb begin
        load_s    = 1'b0;
        step_s    = 1'b0;
        last_s    = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = in_valid;
            end
            RUN: begin
                step_s = 1'b1;
                last_s = (cnt_r == LAST_IDX);
            end
            DONE: begin
                release_s = out_ready;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Select the operand slice for the current group.
    always_comb begin
        base_s  = int'(cnt_r) * G;
        grp_a_s = a_r[base_s +: G];
        grp_b_s = b_r[base_s +: G];
    end

    cla_addsub_seq_group #(.G(G)) u_group (
        .a     (grp_a_s),
        .b     (grp_b_s),
        .cin   (carry_r),
        .sum   (grp_sum_s),
        .cout  (grp_cout_s),
        .c_msb (grp_c_msb_s)
    );

    // Operand capture, group stepping and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            in_ready_r <= (state_next_s == IDLE);
            if (load_s) begin
                // Subtraction folds into the adder by inverting b and the borrow.
                a_r     <= a;
                b_r     <= b ^ {N{sub}};
                carry_r <= cin ^ sub;
                cnt_r   <= '0;
                sum_r   <= '0;
                cout_r  <= 1'b0;
                ovf_r   <= 1'b0;
            end else if (step_s) begin
                sum_r[base_s +: G] <= grp_sum_s;
                carry_r            <= grp_cout_s;
                cnt_r              <= cnt_r + CW'(1);
                if (last_s) begin
                    cout_r      <= grp_cout_s;
                    ovf_r       <= grp_c_msb_s ^ grp_cout_s;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= out_valid_r;
                end
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Directed bench for cla_addsub_seq: N=32/G=4 vector table plus hold and
// reset-abort sequences, and N=8 with G=1, 4 and 8 side by side.
module tb_cla_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_valid8 = 1'b0;
    logic [7:0]  a8 = 8'h0;
    logic [7:0]  b8 = 8'h0;
    logic        out_ready8 = 1'b0;
    logic [2:0]  in_ready8;
    logic [2:0]  out_valid8;
    logic [7:0]  sum8 [3];
    logic [2:0]  cout8;
    logic [2:0]  ovf8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_addsub_seq #(.N(32), .G(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_addsub_seq #(.N(8), .G(1)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8[0]),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(out_valid8[0]),
        .out_ready(out_ready8), .sum(sum8[0]), .cout(cout8[0]), .ovf(ovf8[0])
    );

    cla_addsub_seq #(.N(8), .G(4)) dut_g4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8[1]),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(out_valid8[1]),
        .out_ready(out_ready8), .sum(sum8[1]), .cout(cout8[1]), .ovf(ovf8[1])
    );

    cla_addsub_seq #(.N(8), .G(8)) dut_g8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8[2]),
        .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(out_valid8[2]),
        .out_ready(out_ready8), .sum(sum8[2]), .cout(cout8[2]), .ovf(ovf8[2])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one operand set to the 32-bit DUT, measure latency, check, release.
    task automatic run_op(input vec_t v, input string name);
        int waited;
        int lat;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({name, " ready"}, 64'(in_ready), 64'd1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd8);
        check({name, " sum"}, 64'(sum), 64'(v.s));
        check({name, " cout"}, 64'(cout), 64'(v.co));
        check({name, " ovf"}, 64'(ovf), 64'(v.ov));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat8 [3];
        vec_t hv;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vecs[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};

        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Result held while the consumer stalls; stray in_valid ignored.
        hv = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0};
        @(negedge clk);
        a = hv.a; b = hv.b; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                a = 32'hDEADBEEF; b = 32'h01010101; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("hold%0d out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d sum", k), 64'(sum), 64'h7);
            check($sformatf("hold%0d cout", k), 64'(cout), 64'd0);
            check($sformatf("hold%0d in_ready", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release out_valid", 64'(out_valid), 64'd0);
        check("release in_ready", 64'(in_ready), 64'd1);
        check("release sum kept", 64'(sum), 64'h7);

        // Reset during the third RUN cycle aborts the operation.
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort sum", 64'(sum), 64'd0);
        check("abort cout", 64'(cout), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hv = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        run_op(hv, "after_abort");

        // N=8 with three group widths in parallel.
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h5B; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        for (int d = 0; d < 3; d++) lat8[d] = -1;
        for (int k = 1; k <= 20; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid8[d] && lat8[d] < 0) lat8[d] = k - 1;
            end
            if (out_valid8 != 3'b111) @(negedge clk);
        end
        check("n8 g1 latency", 64'(lat8[0]), 64'd8);
        check("n8 g4 latency", 64'(lat8[1]), 64'd2);
        check("n8 g8 latency", 64'(lat8[2]), 64'd1);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("n8 dut%0d sum", d), 64'(sum8[d]), 64'h00);
            check($sformatf("n8 dut%0d cout", d), 64'(cout8[d]), 64'd1);
            check($sformatf("n8 dut%0d ovf", d), 64'(ovf8[d]), 64'd0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("n8 release in_ready", 64'(in_ready8), 64'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
